// File: rtl/serial_compare_arbiter.sv
// serial_compare_arbiter
// Shares one external MSB-first bit-serial comparator between N_REQ requesters.
// A round-robin arbiter picks one parallel operand pair, the comparator is
// cleared for one cycle, the bits are streamed MSB-first, and the
// less/eq/greater verdict is returned with the requester index. Only one
// operation is in flight at a time.
module serial_compare_arbiter #(
    parameter int WIDTH      = 8,
    parameter int N_REQ      = 2,
    parameter int EARLY_EXIT = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req_valid,
    output logic [N_REQ-1:0]         req_ready,
    input  logic [N_REQ*WIDTH-1:0]   req_a,
    input  logic [N_REQ*WIDTH-1:0]   req_b,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [$clog2(N_REQ)-1:0] res_id,
    output logic                     res_less,
    output logic                     res_eq,
    output logic                     res_greater,
    output logic                     cmp_rst,
    output logic                     cmp_a,
    output logic                     cmp_b,
    input  logic                     cmp_less,
    input  logic                     cmp_eq,
    input  logic                     cmp_greater
);

    localparam int ID_W  = $clog2(N_REQ);
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLR   = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state_reg;
    state_t            state_next;
    logic [ID_W-1:0]   rr_reg;
    logic [ID_W-1:0]   id_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [WIDTH-1:0]  a_reg;
    logic [WIDTH-1:0]  b_reg;
    logic              res_less_reg;
    logic              res_eq_reg;
    logic              res_greater_reg;

    logic [WIDTH-1:0]  a_arr   [N_REQ];
    logic [WIDTH-1:0]  b_arr   [N_REQ];
    logic [ID_W-1:0]   rot_idx [N_REQ];
    logic [N_REQ-1:0]  cand;
    logic              grant_found;
    logic [ID_W-1:0]   grant_idx;
    logic              shift_last;

    // Unpack operands and build the request vector rotated so that position 0
    // is the requester the round-robin pointer currently favours.
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
            logic [ID_W:0] rot_sum;
            assign a_arr[gi]   = req_a[gi*WIDTH +: WIDTH];
            assign b_arr[gi]   = req_b[gi*WIDTH +: WIDTH];
            assign rot_sum     = {1'b0, rr_reg} + (ID_W+1)'(gi);
            assign rot_idx[gi] = (rot_sum >= (ID_W+1)'(N_REQ))
                               ? ID_W'(rot_sum - (ID_W+1)'(N_REQ))
                               : rot_sum[ID_W-1:0];
            assign cand[gi]    = req_valid[rot_idx[gi]];
        end
    endgenerate

    // Priority pick: lowest rotated position wins, i.e. first valid requester
    // at or above the pointer with wrap-around.
    always_comb begin
        grant_found = |cand;
        grant_idx   = rot_idx[0];
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (cand[i]) begin
                grant_idx = rot_idx[i];
            end
        end
    end

    // Last shift cycle: LSB reached, or the comparator has already decided.
    assign shift_last = (cnt_reg == '0) || ((EARLY_EXIT != 0) && !cmp_eq);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic and the combinational grant toward the requesters.
    always_comb begin
        state_next = state_reg;
        req_ready  = '0;
        case (state_reg)
            IDLE: begin
                if (grant_found && rst_n) begin
                    req_ready[grant_idx] = 1'b1;
                    state_next           = CLR;
                end
            end
            CLR:     state_next = SHIFT;
            SHIFT:   if (shift_last) state_next = DONE;
            DONE:    if (res_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operand latch, bit counter, verdict capture and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_reg          <= '0;
            id_reg          <= '0;
            cnt_reg         <= '0;
            a_reg           <= '0;
            b_reg           <= '0;
            res_less_reg    <= 1'b0;
            res_eq_reg      <= 1'b0;
            res_greater_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (grant_found) begin
                        a_reg  <= a_arr[grant_idx];
                        b_reg  <= b_arr[grant_idx];
                        id_reg <= grant_idx;
                    end
                end
                CLR: begin
                    cnt_reg <= CNT_W'(WIDTH - 1);
                end
                SHIFT: begin
                    cnt_reg <= cnt_reg - 1'b1;
                    if (shift_last) begin
                        res_less_reg    <= cmp_less;
                        res_eq_reg      <= cmp_eq;
                        res_greater_reg <= cmp_greater;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        rr_reg <= (id_reg == ID_W'(N_REQ - 1)) ? '0 : id_reg + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Output decode: comparator is cleared in CLR (and while in reset), bits
    // are presented only during SHIFT.
    assign res_valid   = (state_reg == DONE);
    assign res_id      = id_reg;
    assign res_less    = res_less_reg;
    assign res_eq      = res_eq_reg;
    assign res_greater = res_greater_reg;
    assign cmp_rst     = !rst_n || (state_reg == CLR);
    assign cmp_a       = (state_reg == SHIFT) && a_reg[cnt_reg];
    assign cmp_b       = (state_reg == SHIFT) && b_reg[cnt_reg];

endmodule
